// File: rtl/miner_multilane.sv
// Multi-lane nonce-range miner: issues LANES nonces per cycle into tagged hash pipelines and
// queues target hits in a found-FIFO. The digest stage is a fixed-latency stand-in for groestl512.
module miner_multilane #(
    parameter int LANES      = 4,
    parameter int CORES      = 1,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic [639:0] i_block,
    input  logic [31:0]  i_nonce_start,
    input  logic [31:0]  i_nonce_end,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_found_valid,
    input  logic         i_found_ready,
    output logic [31:0]  o_found_nonce,
    output logic [31:0]  o_found_hash,
    output logic         o_overflow,
    output logic [47:0]  o_hash_count
);

    localparam int          AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [32:0] STEP = 33'(LANES * CORES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [607:0]     r_hdr;
    logic [31:0]      r_target;
    logic [31:0]      r_base;
    logic [31:0]      r_span;
    logic [32:0]      r_off;
    logic [LANES-1:0] r_pv [PIPE_LAT];
    logic [31:0]      r_pn [PIPE_LAT][LANES];
    logic [63:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [47:0]      r_hash_count;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_issue_en;
    logic [32:0]      w_off_nxt;
    logic [LANES-1:0] w_issue_v;
    logic [31:0]      w_issue_n [LANES];
    logic [31:0]      w_hdr_fold;
    logic [31:0]      w_word [LANES];
    logic [LANES-1:0] w_hit;
    logic [31:0]      w_nhits;
    logic             w_any_hit;
    logic             w_multi;
    logic [31:0]      w_sel_nonce;
    logic [31:0]      w_sel_word;
    logic [47:0]      w_exit_cnt;
    logic [48:0]      w_hc_sum;
    logic             w_inflight;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    // Stand-in double-hash digest of block0 = {hdr, nonce, 8'h80}; replace with groestl512 cores.
    function automatic logic [511:0] digest_stub(input logic [31:0] hdr_fold, input logic [31:0] nonce);
        return {16{hdr_fold ^ nonce}};
    endfunction

    function automatic logic [31:0] compare_word(input logic [511:0] h);
        return {h[263:256], h[271:264], h[279:272], h[287:280]};
    endfunction

    assign w_load     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_issue_en = (r_state == S_RUN) && !i_stop;
    assign w_off_nxt  = r_off + STEP;

    // Per-lane nonce and range mask for this cycle's issue.
    always_comb begin
        w_issue_v = '0;
        for (int i = 0; i < LANES; i++) begin
            w_issue_n[i] = r_base + 32'(i);
            w_issue_v[i] = w_issue_en && ((r_off + 33'(i)) <= {1'b0, r_span});
        end
    end

    // Control FSM next-state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = (i_stop || (w_off_nxt > {1'b0, r_span})) ? S_DRAIN : S_RUN;
            S_DRAIN: w_state_nxt = w_inflight ? S_DRAIN : S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_RUN : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control FSM state and decoded status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Job registers and nonce/offset cursor.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hdr    <= '0;
            r_target <= 32'd0;
            r_base   <= 32'd0;
            r_span   <= 32'd0;
            r_off    <= 33'd0;
        end else if (w_load) begin
            r_hdr    <= i_block[639:32];
            r_target <= i_block[31:0];
            r_base   <= i_nonce_start;
            r_span   <= i_nonce_end - i_nonce_start;
            r_off    <= 33'd0;
        end else if (w_issue_en) begin
            r_base   <= r_base + STEP[31:0];
            r_off    <= w_off_nxt;
        end
    end

    // Tag shift register carrying {valid, nonce} per lane alongside the hash latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_pv[k] <= '0;
                for (int i = 0; i < LANES; i++) begin
                    r_pn[k][i] <= 32'd0;
                end
            end
        end else begin
            r_pv[0] <= w_issue_v;
            for (int i = 0; i < LANES; i++) begin
                r_pn[0][i] <= w_issue_n[i];
            end
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                for (int i = 0; i < LANES; i++) begin
                    r_pn[k][i] <= r_pn[k-1][i];
                end
            end
        end
    end

    // Stages before the last must be empty for DRAIN to finish as the last stage is compared.
    always_comb begin
        w_inflight = 1'b0;
        for (int k = 0; k < PIPE_LAT - 1; k++) begin
            w_inflight = w_inflight | (|r_pv[k]);
        end
    end

    // Header contribution to the stand-in digest.
    always_comb begin
        w_hdr_fold = 32'd0;
        for (int j = 0; j < 19; j++) begin
            w_hdr_fold = w_hdr_fold ^ r_hdr[32*j +: 32];
        end
    end

    // Compare at pipeline exit; lowest-index hit wins the single push slot.
    always_comb begin
        w_hit       = '0;
        w_nhits     = 32'd0;
        w_sel_nonce = 32'd0;
        w_sel_word  = 32'd0;
        w_exit_cnt  = 48'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            w_word[i]   = compare_word(digest_stub(w_hdr_fold, r_pn[PIPE_LAT-1][i]));
            w_hit[i]    = r_pv[PIPE_LAT-1][i] && (w_word[i] <= r_target);
            w_nhits     = w_nhits + 32'(w_hit[i]);
            w_exit_cnt  = w_exit_cnt + 48'(r_pv[PIPE_LAT-1][i]);
            w_sel_nonce = w_hit[i] ? r_pn[PIPE_LAT-1][i] : w_sel_nonce;
            w_sel_word  = w_hit[i] ? w_word[i] : w_sel_word;
        end
    end

    assign w_any_hit = |w_hit;
    assign w_multi   = (w_nhits > 32'd1);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push    = w_any_hit && !w_full;
    assign w_pop     = (r_count != '0) && i_found_ready;
    assign w_drop    = w_multi || (w_any_hit && w_full);
    assign w_hc_sum  = {1'b0, r_hash_count} + {1'b0, w_exit_cnt};

    // Found-FIFO, sticky overflow and saturating hash counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_mem[e] <= 64'd0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_hash_count <= 48'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_sel_word, w_sel_nonce};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_load) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_hash_count <= 48'd0;
            end else if (w_hc_sum[48]) begin
                r_hash_count <= {48{1'b1}};
            end else begin
                r_hash_count <= w_hc_sum[47:0];
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_found_valid = (r_count != '0);
    assign o_found_nonce = r_mem[r_rd_ptr][31:0];
    assign o_found_hash  = r_mem[r_rd_ptr][63:32];
    assign o_overflow    = r_overflow;
    assign o_hash_count  = r_hash_count;

endmodule

// File: tb/tb_miner_multilane.sv
// Directed bench for miner_multilane: a job table run to completion, plus stop, FIFO-full
// and reset-in-DRAIN sequences. With an all-zero header the compare word is byteswap(nonce).
module tb_miner_multilane;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, start1, stop;
    logic [639:0] block;
    logic [31:0]  nonce_start, nonce_end;
    logic         found_ready, found_ready1;
    logic         busy, done, found_valid, overflow;
    logic [31:0]  found_nonce, found_hash;
    logic [47:0]  hash_count;
    logic         busy1, done1, found_valid1, overflow1;
    logic [31:0]  found_nonce1, found_hash1;
    logic [47:0]  hash_count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    miner_multilane #(.LANES(4), .CORES(1), .PIPE_LAT(2), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_block(block),
        .i_nonce_start(nonce_start), .i_nonce_end(nonce_end),
        .o_busy(busy), .o_done(done), .o_found_valid(found_valid), .i_found_ready(found_ready),
        .o_found_nonce(found_nonce), .o_found_hash(found_hash), .o_overflow(overflow),
        .o_hash_count(hash_count)
    );

    miner_multilane #(.LANES(1), .CORES(1), .PIPE_LAT(2), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start1), .i_stop(1'b0), .i_block(block),
        .i_nonce_start(nonce_start), .i_nonce_end(nonce_end),
        .o_busy(busy1), .o_done(done1), .o_found_valid(found_valid1), .i_found_ready(found_ready1),
        .o_found_nonce(found_nonce1), .o_found_hash(found_hash1), .o_overflow(overflow1),
        .o_hash_count(hash_count1)
    );

    typedef struct {
        logic [31:0] ns;
        logic [31:0] ne;
        logic [31:0] tgt;
        int          hc;
        int          pops;
        logic [31:0] first;
        logic [31:0] first_hash;
        logic [31:0] last;
        logic        ovf;
        int          busy_cyc;
    } job_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input int idx, input job_t j);
        int          pops, bcyc;
        logic [31:0] first, first_h, last;
        bit          finished;
        pops = 0; bcyc = 0; first = 32'd0; first_h = 32'd0; last = 32'd0; finished = 1'b0;
        @(negedge clk);
        block       = {608'd0, j.tgt};
        nonce_start = j.ns;
        nonce_end   = j.ne;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (busy) bcyc++;
            if (found_valid) begin
                if (pops == 0) begin
                    first   = found_nonce;
                    first_h = found_hash;
                end
                last = found_nonce;
                pops++;
            end
            if (done && !found_valid) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("job%0d_finished", idx), 64'(finished), 64'd1);
        chk($sformatf("job%0d_hash_count", idx), 64'(hash_count), 64'(j.hc));
        chk($sformatf("job%0d_pops", idx), 64'(pops), 64'(j.pops));
        chk($sformatf("job%0d_overflow", idx), 64'(overflow), 64'(j.ovf));
        chk($sformatf("job%0d_busy_cycles", idx), 64'(bcyc), 64'(j.busy_cyc));
        if (j.pops > 0) begin
            chk($sformatf("job%0d_first_nonce", idx), 64'(first), 64'(j.first));
            chk($sformatf("job%0d_first_hash", idx), 64'(first_h), 64'(j.first_hash));
            chk($sformatf("job%0d_last_nonce", idx), 64'(last), 64'(j.last));
        end
    endtask

    initial begin
        job_t jobs [6];
        bit   seen;
        jobs[0] = '{32'h100, 32'h10B, 32'hFFFFFFFF, 12, 3, 32'h100, 32'h00010000, 32'h108, 1'b1, 5};
        jobs[1] = '{32'h105, 32'h106, 32'hFFFFFFFF, 2, 1, 32'h105, 32'h05010000, 32'h105, 1'b1, 3};
        jobs[2] = '{32'hFFFFFFFE, 32'h1, 32'h0, 4, 1, 32'h0, 32'h0, 32'h0, 1'b0, 3};
        jobs[3] = '{32'h10, 32'h10, 32'hFFFFFFFF, 1, 1, 32'h10, 32'h10000000, 32'h10, 1'b0, 3};
        jobs[4] = '{32'h0, 32'h7, 32'h01000000, 8, 1, 32'h0, 32'h0, 32'h0, 1'b1, 4};
        jobs[5] = '{32'h1, 32'h1, 32'h00FFFFFF, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0, 3};

        reset = 1'b1; start = 1'b0; start1 = 1'b0; stop = 1'b0;
        block = '0; nonce_start = 32'd0; nonce_end = 32'd0;
        found_ready = 1'b1; found_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_found_valid", 64'(found_valid), 64'd0);
        chk("reset_found_nonce", 64'(found_nonce), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_hash_count", 64'(hash_count), 64'd0);
        chk("reset_dut1_found_valid", 64'(found_valid1), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_job(i, jobs[i]);
        end

        // stop on the second RUN cycle: only the first issue completes
        @(negedge clk);
        block = {608'd0, 32'hFFFFFFFF}; nonce_start = 32'd0; nonce_end = 32'h0000FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("stop_run1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_drain_busy", 64'(busy), 64'd1);
        chk("stop_drain_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("stop_busy_fall", 64'(busy), 64'd0);
        chk("stop_done", 64'(done), 64'd1);
        chk("stop_hash_count", 64'(hash_count), 64'd4);
        chk("stop_found_nonce", 64'(found_nonce), 64'd0);
        chk("stop_overflow", 64'(overflow), 64'd1);
        repeat (3) @(negedge clk);
        chk("stop_fifo_empty", 64'(found_valid), 64'd0);

        // single-lane instance, FIFO held full: fifth hit is dropped
        block = {608'd0, 32'hFFFFFFFF}; nonce_start = 32'h20; nonce_end = 32'h24;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("full_done", 64'(seen), 64'd1);
        chk("full_hash_count", 64'(hash_count1), 64'd5);
        chk("full_overflow", 64'(overflow1), 64'd1);
        found_ready1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full_pop%0d_valid", k), 64'(found_valid1), 64'd1);
            chk($sformatf("full_pop%0d_nonce", k), 64'(found_nonce1), 64'(32'h20 + k));
            @(negedge clk);
        end
        chk("full_empty_after_pops", 64'(found_valid1), 64'd0);

        // reset while DRAIN still holds tagged work
        found_ready = 1'b0;
        block = {608'd0, 32'hFFFFFFFF}; nonce_start = 32'd0; nonce_end = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_found_valid", 64'(found_valid), 64'd0);
        chk("rst_hash_count", 64'(hash_count), 64'd0);
        repeat (5) @(negedge clk);
        chk("rst_later_found_valid", 64'(found_valid), 64'd0);
        chk("rst_later_hash_count", 64'(hash_count), 64'd0);
        chk("rst_later_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
